// File: rtl/k_and_s_control_unit.sv
// K&S 16-bit processor control unit: Moore FSM that sequences fetch, decode and a
// single execute step per instruction, driving every datapath and RAM enable.
package k_and_s_pkg;

    typedef logic [15:0] decoded_instruction_type;

    // Bit position of each instruction in the one-hot decoded word.
    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } instr_idx_e;

    typedef enum logic [1:0] {
        ALU_OR  = 2'b00,
        ALU_ADD = 2'b01,
        ALU_SUB = 2'b10,
        ALU_AND = 2'b11
    } alu_op_e;

endpackage

module k_and_s_control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    ir_enable,
    output logic                    pc_enable,
    output logic                    branch,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_LOAD,
        ST_STORE,
        ST_ALU,
        ST_BRANCH,
        ST_HALT
    } state_e;

    state_e state, next_state;
    logic   valid_code;
    logic   is_alu;
    logic   is_branch;
    logic   taken;

    // Zero or multi-bit codes fall through to the NOP path.
    assign valid_code = (decoded_instruction != '0) &&
                        ((decoded_instruction & (decoded_instruction - 16'd1)) == '0);

    assign is_alu = |{decoded_instruction[I_MOVE], decoded_instruction[I_ADD],
                      decoded_instruction[I_SUB],  decoded_instruction[I_AND],
                      decoded_instruction[I_OR]};

    assign is_branch = |{decoded_instruction[I_BRANCH], decoded_instruction[I_BZERO],
                         decoded_instruction[I_BNZERO], decoded_instruction[I_BNEG],
                         decoded_instruction[I_BNNEG],  decoded_instruction[I_BOV],
                         decoded_instruction[I_BNOV]};

    // NOTE: combinational blocks assign a default to every output first so no latch is inferred.
    always_comb begin
        taken = 1'b0;
        if (decoded_instruction[I_BRANCH])      taken = 1'b1;
        else if (decoded_instruction[I_BZERO])  taken = zero_op;
        else if (decoded_instruction[I_BNZERO]) taken = !zero_op;
        else if (decoded_instruction[I_BNEG])   taken = neg_op;
        else if (decoded_instruction[I_BNNEG])  taken = !neg_op;
        else if (decoded_instruction[I_BOV])    taken = unsigned_overflow | signed_overflow;
        else if (decoded_instruction[I_BNOV])   taken = !(unsigned_overflow | signed_overflow);
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RST;
        else        state <= next_state;
    end

    always_comb begin
        next_state       = state;
        ir_enable        = 1'b0;
        pc_enable        = 1'b0;
        branch           = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = ALU_OR;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;

        case (state)
            ST_RST: next_state = ST_FETCH;

            ST_FETCH: begin
                ir_enable  = 1'b1;
                next_state = ST_DECODE;
            end

            ST_DECODE: begin
                pc_enable = 1'b1;
                if (!valid_code)                          next_state = ST_FETCH;
                else if (decoded_instruction[I_LOAD])     next_state = ST_LOAD;
                else if (decoded_instruction[I_STORE])    next_state = ST_STORE;
                else if (is_alu)                          next_state = ST_ALU;
                else if (is_branch)                       next_state = ST_BRANCH;
                else if (decoded_instruction[I_HALT])     next_state = ST_HALT;
                else                                      next_state = ST_FETCH;
            end

            ST_LOAD: begin
                addr_sel         = 1'b1;
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                next_state       = ST_FETCH;
            end

            ST_STORE: begin
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
                next_state       = ST_FETCH;
            end

            ST_ALU: begin
                write_reg_enable = 1'b1;
                if (decoded_instruction[I_ADD])      operation = ALU_ADD;
                else if (decoded_instruction[I_SUB]) operation = ALU_SUB;
                else if (decoded_instruction[I_AND]) operation = ALU_AND;
                // MOVE passes its operand through the OR path and leaves the flags alone.
                flags_reg_enable = |{decoded_instruction[I_ADD], decoded_instruction[I_SUB],
                                     decoded_instruction[I_AND], decoded_instruction[I_OR]};
                next_state       = ST_FETCH;
            end

            ST_BRANCH: begin
                branch     = 1'b1;
                pc_enable  = taken;
                next_state = ST_FETCH;
            end

            ST_HALT: begin
                halt       = 1'b1;
                next_state = ST_HALT;
            end

            default: next_state = ST_RST;
        endcase
    end

endmodule

// File: tb/tb_k_and_s_control_unit.sv
// Scoreboard bench for k_and_s_control_unit: the driver pushes per-cycle expected
// outputs from an instruction-level model; a negedge monitor pops and compares.
module tb_k_and_s_control_unit;
    import k_and_s_pkg::*;

    typedef struct packed {
        logic       ir;
        logic       pc;
        logic       br;
        logic       as;
        logic       cs;
        logic [1:0] op;
        logic       wr;
        logic       fl;
        logic       rw;
        logic       h;
    } outs_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] decoded_instruction;
    logic        zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic        ir_enable, pc_enable, branch, addr_sel, c_sel;
    logic [1:0]  operation;
    logic        write_reg_enable, flags_reg_enable, ram_write_enable, halt;

    int errors = 0;
    int checks = 0;

    outs_t exp_q[$];
    string name_q[$];

    k_and_s_control_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ir_enable           (ir_enable),
        .pc_enable           (pc_enable),
        .branch              (branch),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .ram_write_enable    (ram_write_enable),
        .halt                (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t actual();
        return {ir_enable, pc_enable, branch, addr_sel, c_sel, operation,
                write_reg_enable, flags_reg_enable, ram_write_enable, halt};
    endfunction

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic push(input outs_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one expected record per sampled cycle, plus the exclusivity rule.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            outs_t e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = actual();
            check(nm, 16'(a), 16'(e));
            check({nm, "_excl"}, 16'(int'(write_reg_enable) + int'(ram_write_enable) + int'(ir_enable) <= 1), 16'd1);
        end
    end

    function automatic outs_t zero_outs();
        outs_t e;
        e = '0;
        return e;
    endfunction

    // Instruction-level reference: a code word and a flag set expand into the
    // sequence of per-cycle control words the processor must see.
    task automatic issue(input logic [15:0] code, input logic [3:0] flg, input string nm, input int halt_cycles);
        outs_t e;
        int    idx;
        int    n;
        logic  z, ng, ov;
        decoded_instruction = code;
        {zero_op, neg_op, unsigned_overflow, signed_overflow} = flg;
        z  = flg[3];
        ng = flg[2];
        ov = flg[1] | flg[0];

        e = '0; e.ir = 1'b1; push(e, {nm, "_fetch"});
        e = '0; e.pc = 1'b1; push(e, {nm, "_decode"});
        n = 2;

        idx = -1;
        if ($countones(code) == 1)
            for (int i = 0; i < 16; i++) if (code[i]) idx = i;

        if (idx >= 0) begin
            e = '0;
            n = 3;
            case (instr_idx_e'(idx[3:0]))
                I_LOAD:  begin e.as = 1; e.cs = 1; e.wr = 1; end
                I_STORE: begin e.as = 1; e.rw = 1; end
                I_MOVE:  begin e.wr = 1; e.op = 2'b00; e.fl = 0; end
                I_ADD:   begin e.wr = 1; e.op = 2'b01; e.fl = 1; end
                I_SUB:   begin e.wr = 1; e.op = 2'b10; e.fl = 1; end
                I_AND:   begin e.wr = 1; e.op = 2'b11; e.fl = 1; end
                I_OR:    begin e.wr = 1; e.op = 2'b00; e.fl = 1; end
                I_BRANCH: begin e.br = 1; e.pc = 1;   end
                I_BZERO:  begin e.br = 1; e.pc = z;   end
                I_BNZERO: begin e.br = 1; e.pc = !z;  end
                I_BNEG:   begin e.br = 1; e.pc = ng;  end
                I_BNNEG:  begin e.br = 1; e.pc = !ng; end
                I_BOV:    begin e.br = 1; e.pc = ov;  end
                I_BNOV:   begin e.br = 1; e.pc = !ov; end
                I_HALT:   begin e.h = 1; n = 2 + halt_cycles; end
                default:  n = 2;
            endcase
            if (instr_idx_e'(idx[3:0]) == I_HALT) begin
                for (int i = 0; i < halt_cycles; i++) push(e, {nm, "_halted"});
            end else if (n == 3) begin
                push(e, {nm, "_exec"});
            end
        end
        tick(n);
    endtask

    function automatic logic [15:0] op1h(input instr_idx_e i);
        logic [15:0] v;
        v = 16'h0001;
        return v << i;
    endfunction

    initial begin
        logic [15:0] code;
        decoded_instruction = '0;
        {zero_op, neg_op, unsigned_overflow, signed_overflow} = 4'b0000;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        tick(1);
        for (int i = 0; i < 3; i++) push(zero_outs(), "reset_hold");
        decoded_instruction = op1h(I_STORE);
        tick(3);
        rst_n = 1'b1;
        push(zero_outs(), "reset_release");
        tick(1);

        issue(op1h(I_ADD),    4'b0000, "add",        0);
        issue(op1h(I_BZERO),  4'b1000, "bzero_z1",   0);
        issue(op1h(I_BNZERO), 4'b1000, "bnzero_z1",  0);
        issue(op1h(I_BNOV),   4'b0001, "bnov_sov1",  0);
        issue(op1h(I_LOAD),   4'b0110, "load",       0);
        issue(op1h(I_STORE),  4'b1001, "store",      0);
        issue(op1h(I_MOVE),   4'b1111, "move",       0);
        issue(16'h0000,       4'b0000, "zero_code",  0);
        issue(16'h0003,       4'b1010, "multi_hot",  0);
        issue(op1h(I_NOP),    4'b0101, "nop",        0);
        issue(op1h(I_BOV),    4'b0010, "bov_uov1",   0);
        issue(op1h(I_BNNEG),  4'b0100, "bnneg_n1",   0);

        for (int k = 0; k < 80; k++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r == 15) code = 16'($urandom);
            else         code = 16'h0001 << r;
            if (code == op1h(I_HALT)) code = 16'h0000;
            issue(code, 4'($urandom_range(0, 15)), "rand", 0);
        end

        issue(op1h(I_HALT), 4'($urandom_range(0, 15)), "halt", 20);

        rst_n = 1'b0;
        push(zero_outs(), "halt_reset");
        tick(1);
        push(zero_outs(), "halt_reset_hold");
        tick(1);
        rst_n = 1'b1;
        push(zero_outs(), "halt_reset_release");
        tick(1);

        decoded_instruction = op1h(I_STORE);
        push('{ir: 1'b1, default: '0}, "store2_fetch");
        push('{pc: 1'b1, default: '0}, "store2_decode");
        tick(2);
        check("store2_write_active", 16'(ram_write_enable), 16'd1);
        #1 rst_n = 1'b0;
        #1;
        check("store2_write_drop", 16'(ram_write_enable), 16'd0);
        check("store2_reset_outs", 16'(actual()), 16'd0);
        push(zero_outs(), "store2_reset");
        tick(1);
        push(zero_outs(), "store2_reset_hold");
        tick(1);
        rst_n = 1'b1;
        push(zero_outs(), "store2_release");
        tick(1);

        issue(op1h(I_SUB),    4'b0011, "sub_after_reset", 0);
        issue(op1h(I_BNOV),   4'b0000, "bnov_clear",      0);
        issue(op1h(I_BNEG),   4'b0000, "bneg_clear",      0);

        tick(2);
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/k_and_s_control_unit.md
# k_and_s_control_unit

Moore-style control FSM for the K&S 16-bit processor. Consumes the one-hot decoded instruction from the instruction register decoder and the stored ALU flags. Produces every enable and select that sequences the datapath (PC, IR, register file, flags register, ALU) and the shared program/data RAM. It is the only block that owns instruction sequencing: fetch, decode, one execute step, repeat until HALT.

## Interface
Parameters:
- none (instruction set fixed by `k_and_s_pkg`)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `decoded_instruction`  in  16  `decoded_instruction_type` from `k_and_s_pkg`, one-hot, valid while IR holds the instruction
- `zero_op`  in  1  stored zero flag
- `neg_op`  in  1  stored negative flag
- `unsigned_overflow`  in  1  stored unsigned-overflow flag
- `signed_overflow`  in  1  stored signed-overflow flag
- `ir_enable`  out  1  IR loads RAM read data at the clock edge
- `pc_enable`  out  1  PC updates at the clock edge
- `branch`  out  1  PC source: 0 = PC+1, 1 = IR address field
- `addr_sel`  out  1  RAM address: 0 = PC, 1 = IR address field
- `c_sel`  out  1  register write data: 0 = ALU result, 1 = RAM read data
- `operation`  out  2  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
- `write_reg_enable`  out  1  register file writes the destination register
- `flags_reg_enable`  out  1  flags register captures ALU flags
- `ram_write_enable`  out  1  RAM writes the source register at the IR address
- `halt`  out  1  processor stopped

## Operation
- Single clock domain (`clk`). Asynchronous active-low reset (`rst_n`): state forced to RST while low.
- All outputs are decoded from the state register and `decoded_instruction` only. There is no combinational path from the flags to any output except `pc_enable` in BRANCH.
- Outputs not listed for a state are 0.
- RAM read is combinational, so the address driven in a cycle is read in that same cycle.

States:
- RST: all outputs 0. Next state FETCH.
- FETCH: `addr_sel`=0, `ir_enable`=1. Next state DECODE.
- DECODE: `pc_enable`=1, `branch`=0 (PC increments).
  - NOP -> FETCH.
  - LOAD -> LOAD.
  - STORE -> STORE.
  - MOVE/ADD/SUB/AND/OR -> ALU.
  - Any branch (BRANCH through BNOV) -> BRANCH.
  - HALT -> HALT.
  - Zero or non-one-hot code -> treated as NOP.
- LOAD: `addr_sel`=1, `c_sel`=1, `write_reg_enable`=1. Next state FETCH.
- STORE: `addr_sel`=1, `ram_write_enable`=1. Next state FETCH.
- ALU: `c_sel`=0, `write_reg_enable`=1.
  - `operation`: ADD 01, SUB 10, AND 11, OR 00, MOVE 00.
  - `flags_reg_enable`=1 for ADD/SUB/AND/OR; 0 for MOVE (MOVE never changes flags).
  - Next state FETCH.
- BRANCH: `branch`=1; `pc_enable`=taken. Next state FETCH.
  - BRANCH: always taken.
  - BZERO: taken if `zero_op`; BNZERO: if !`zero_op`.
  - BNEG: taken if `neg_op`; BNNEG: if !`neg_op`.
  - BOV: taken if `unsigned_overflow`|`signed_overflow`; BNOV: the inverse.
- HALT: `halt`=1. Stays in HALT until `rst_n` is asserted.

## Timing
- Reset values (RST state): every output 0.
  - First FETCH happens in the cycle after the first rising edge of `clk` following `rst_n` deassertion.
- Latency per instruction (FETCH through last state):
  - NOP: 2 cycles.
  - LOAD, STORE, ALU ops, MOVE: 3 cycles.
  - Any branch, taken or not: 3 cycles.
- Flags are stable in BRANCH: the flags register only updates in ALU states, and those always complete at least 2 cycles earlier.
- ALU op followed by a conditional branch uses that ALU op's flags. No hazard, no stall.
- Reset asserted mid-instruction: the state goes to RST immediately (asynchronous) and all outputs drop to 0 in the same cycle. No partial RAM write may follow the assertion.
- `halt` rises in the cycle after HALT's DECODE and stays at 1 until reset.
- At most one of `write_reg_enable`, `ram_write_enable`, `ir_enable` is high in any cycle.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release -> all outputs 0 during reset; FETCH with `ir_enable`=1 on the first cycle after the first edge; DECODE with `pc_enable`=1 next.
- ADD then BZERO with `zero_op`=1 -> ALU cycle with `operation`=01, `write_reg_enable`=1, `flags_reg_enable`=1. In the BRANCH cycle, `branch`=1 and `pc_enable`=1.
- BNZERO with `zero_op`=1, then BNOV with `signed_overflow`=1 -> in both BRANCH cycles `pc_enable`=0. Each instruction takes 3 cycles.
- LOAD then STORE -> LOAD cycle: `addr_sel`=1, `c_sel`=1, `write_reg_enable`=1. STORE cycle: `addr_sel`=1, `ram_write_enable`=1, `write_reg_enable`=0.
- MOVE -> `operation`=00, `write_reg_enable`=1, `flags_reg_enable`=0. Then `decoded_instruction`=16'h0000 -> handled as a 2-cycle NOP.
- HALT, with `rst_n` pulsed low during a later STORE cycle (new program) -> `halt`=1 held for 20 cycles with no other enables. On the mid-STORE reset, `ram_write_enable` drops to 0 asynchronously.
